// File: rtl/regfile_dump.sv
// Read-side dump sequencer: walks a wrapping address range through a register-file
// read port and streams each word, tagged with its address, on a valid/ready port.
module regfile_dump #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_last
);

  localparam int unsigned CntW = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   span;

  // Modular difference gives the wrapping range; +1 turns first==last+1 into a full sweep.
  assign span = last_addr - first_addr;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    maddr_d = maddr_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = first_addr;
          cnt_d   = {1'b0, span} + CntW'(1);
          state_d = StRead;
        end
      end
      StRead: begin
        data_d  = rf_rdata;
        maddr_d = addr_q;
        last_d  = (cnt_q == CntW'(1));
        state_d = StSend;
      end
      StSend: begin
        if (m_ready) begin
          if (last_q) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q - CntW'(1);
            state_d = StRead;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
    // Abort overrides everything, including a start seen in idle.
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      maddr_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      maddr_q <= maddr_d;
      last_q  <= last_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign m_valid  = (state_q == StSend);
  assign rf_raddr = addr_q;
  assign m_data   = data_q;
  assign m_addr   = maddr_q;
  assign m_last   = last_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: behavioural register file plus a range/queue model of
// the expected word stream, directed scenarios followed by randomized dumps.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, m_ready;
  logic [4:0]  first_addr, last_addr, rf_raddr, m_addr;
  logic [31:0] rf_rdata, m_data;
  logic        busy, done, m_valid, m_last;

  logic [31:0] regs [32];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rf_rdata = regs[rf_raddr];

  regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
    .m_last(m_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(m_valid), 32'd0);
    chk({tag, "_last"}, 32'(m_last), 32'd0);
    chk({tag, "_data"}, m_data, 32'd0);
    chk({tag, "_addr"}, 32'(m_addr), 32'd0);
    chk({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
  endtask

  // mode 0: ready high; 1: random ready; 2: first word stalled 4 cycles;
  // 3: ready high with start held and junk ranges presented while busy.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int mode);
    logic [4:0]  ea[$];
    logic [31:0] ed[$];
    logic [4:0]  a;
    int n;
    int idx = 0;
    int stall = 0;
    bit hs, pv;
    bit seen_done = 0;
    a = f;
    ea.push_back(a);
    while (a != l) begin
      a = a + 5'd1;
      ea.push_back(a);
    end
    n = ea.size();
    for (int i = 0; i < n; i++) ed.push_back(regs[ea[i]]);

    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    m_ready    = 1'b0;
    @(posedge clk); #1;
    if (mode != 3) start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("read_after_start", 32'(m_valid), 32'd0);
    chk("raddr_first", 32'(rf_raddr), 32'(f));

    for (int c = 1; c <= 400 && !seen_done; c++) begin
      if (mode == 3) begin
        first_addr = 5'($urandom);
        last_addr  = 5'($urandom);
      end
      case (mode)
        1:       m_ready = ($urandom_range(0, 99) < 60);
        2:       m_ready = !(idx == 0 && stall <= 4);
        default: m_ready = 1'b1;
      endcase
      hs = m_valid && m_ready;
      pv = m_valid;
      @(posedge clk); #1;
      if (hs) idx++;
      if (pv && !hs) chk("valid_held", 32'(m_valid), 32'd1);
      if (done) begin
        seen_done = 1;
        start = 1'b0;
        chk("done_words", 32'(idx), 32'(n));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_valid", 32'(m_valid), 32'd0);
        if (mode == 0 || mode == 3) chk("done_latency", 32'(c), 32'(2 * n));
      end else if (m_valid) begin
        if (idx < n) begin
          chk("word_data", m_data, ed[idx]);
          chk("word_addr", 32'(m_addr), 32'(ea[idx]));
          chk("word_last", 32'(m_last), 32'(idx == n - 1));
          chk("send_raddr", 32'(rf_raddr), 32'(ea[idx]));
        end else begin
          chk("extra_word", 32'(idx), 32'(n - 1));
        end
        if (mode == 2 && idx == 0) begin
          stall++;
          // A write during the stall must not disturb the pending word.
          if (stall == 2 && ea[0] != 5'd0) regs[ea[0]] = ~regs[ea[0]];
        end
      end else begin
        chk("read_busy", 32'(busy), 32'd1);
        if (idx < n) chk("read_raddr", 32'(rf_raddr), 32'(ea[idx]));
      end
    end
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_valid", 32'(m_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
    first_addr = '0; last_addr = '0;
    regs[0] = 32'd0;
    for (int i = 1; i < 32; i++) regs[i] = 32'hA5A5_0000 + 32'(i);
    #1;
    chk_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_dump(5'd3, 5'd5, 0);
    run_dump(5'd30, 5'd1, 0);
    run_dump(5'd7, 5'd6, 0);
    run_dump(5'd3, 5'd5, 2);

    // Abort while the second of three words is offered.
    first_addr = 5'd10; last_addr = 5'd12; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; chk("abort_w0_addr", 32'(m_addr), 32'd10);
    @(posedge clk); #1; chk("abort_read", 32'(m_valid), 32'd0);
    @(posedge clk); #1; chk("abort_w1_addr", 32'(m_addr), 32'd11);
    abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("abort_nodone", 32'(done), 32'd0);
    run_dump(5'd0, 5'd0, 0);

    run_dump(5'd3, 5'd5, 3);

    // start together with abort in idle is refused.
    first_addr = 5'd4; last_addr = 5'd8; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("startabort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("startabort_busy2", 32'(busy), 32'd0);
    chk("startabort_valid", 32'(m_valid), 32'd0);

    // Asynchronous reset in the middle of a dump.
    first_addr = 5'd3; last_addr = 5'd5; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("prereset_valid", 32'(m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("postreset_valid", 32'(m_valid), 32'd0);
      chk("postreset_done", 32'(done), 32'd0);
      chk("postreset_busy", 32'(busy), 32'd0);
    end

    for (int t = 0; t < 15; t++) begin
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      run_dump(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), int'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Read-side sequencer for the 32 x 32-bit register file: on command it walks a contiguous address range through one of the file's asynchronous read ports and streams each word out on a valid/ready interface, tagged with its address. It sits between the register file's second read port and a debug/UART transmit path, letting the lab board dump register contents without touching the write port.

## Interface
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register word width
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a dump; sampled only when busy=0
- abort  in  1  synchronous cancel; wins over every other input
- first_addr  in  ADDR_W  first register to dump, captured on accepted start
- last_addr  in  ADDR_W  last register to dump, captured on accepted start
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse after the final word is accepted
- rf_raddr  out  ADDR_W  drives register-file read address
- rf_rdata  in  DATA_W  combinational read data from the register file
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_W  registered word
- m_addr  out  ADDR_W  address the word was read from
- m_last  out  1  high with the final word of the dump

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: busy=0, m_valid=0. start=1 and abort=0 -> capture first_addr into address register, load remaining count = ((last_addr - first_addr) mod 32) + 1 (6-bit), go READ.
- Range wraps modulo 32: first==last -> 1 word; first=last+1 -> all 32 words; e.g. first=30, last=1 -> addresses 30,31,0,1.
- READ (one cycle): rf_raddr = current address; at edge, register rf_rdata into m_data, address into m_addr, m_last = (count==1); go SEND.
- SEND: m_valid=1; m_data/m_addr/m_last held stable until m_valid&&m_ready. On handshake: if m_last -> DONE; else address+1 (wraps 31->0), count-1, go READ.
- DONE (one cycle): done=1, busy=1, m_valid=0; go IDLE.
- start while busy=1 ignored, no queuing.
- abort=1 in any state -> IDLE at next edge; m_valid drops, done not pulsed, count/address discarded. abort with start in IDLE: abort wins, no dump.
- Address 0 word is whatever the register file returns (zero by file design); block applies no special case.
- Word content is the register value at the READ-cycle edge; writes to the file after that edge are not reflected in the pending word.
- m_valid never falls without handshake except on abort or reset.

## Timing
- Reset (rst_n=0, async): state IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0, m_addr=0, rf_raddr=0, count=0. Reset mid-dump abandons it immediately; no done.
- rf_raddr is a register output; equals current address from the cycle after accepted start.
- start sampled at edge k -> READ during cycle k+1 -> m_valid=1 from k+2 with m_data=reg[first_addr].
- Handshake at edge j (not last) -> m_valid=0 in cycle j+1 (READ) -> next word valid from j+2. Peak throughput 1 word / 2 cycles.
- Final handshake at edge j -> done=1 and busy=1 in cycle j+1 -> busy=0 from j+2; new start accepted at edge j+2 earliest.
- Total cycles start-to-done with m_ready tied high: 2*N + 1 for N words.

## Test plan
- Preload reg[i]=0xA5A50000+i; start first=3,last=5, m_ready=1 -> words 0xA5A50003/4/5 with m_addr 3,4,5, m_last only on 5, done pulse 7 cycles after start edge.
- Wrap: first=30,last=1 -> m_addr sequence 30,31,0,1, data for addr 0 = 0x00000000; first=7,last=6 -> 32 words, last m_addr=6.
- Backpressure: m_ready low 4 cycles in SEND for first word -> m_valid stays 1, m_data stable, no address advance; resumes correctly.
- Abort in SEND of second of three words -> m_valid=0 and busy=0 next cycle, no done; subsequent start first=0,last=0 yields one word addr 0 then done.
- start pulsed while busy -> ignored, range unchanged; start+abort together in IDLE -> busy stays 0.
- rst_n asserted mid-dump, asynchronously between edges -> all outputs 0 immediately; after release, no spurious m_valid or done.
